// File: rtl/cipher_pkg.sv
// Shared definitions for the XOR cipher transmit path: FSM encoding,
// default word width and the bit-counter width helper.
package cipher_pkg;

   localparam int DATA_SIZE_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } cipher_state_e;

   // Counter must hold the full word width without wrapping.
   function automatic int cw_of(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: parallel load, enable-gated left shift,
// MSB presented on msb_o. Load has priority over shift.
module piso_shift_reg #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         msb_o
);

   logic [W-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = data_i;
      end else if (shift_i) begin
         shreg_d = {shreg_q[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/cipher_serializer.sv
// XORs the deserialized plaintext and key words and transmits the ciphertext
// MSB first. Starts are refused while either input word is incomplete.
module cipher_serializer
   import cipher_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   localparam int CW = cw_of(DATA_SIZE)
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iEn,
   input  logic                 iStart,
   input  logic [DATA_SIZE-1:0] iData,
   input  logic [DATA_SIZE-1:0] iKey,
   input  logic [CW-1:0]        iData_count,
   input  logic [CW-1:0]        iKey_count,
   output logic                 oSerial,
   output logic                 oValid,
   output logic                 oBusy,
   output logic                 oDone,
   output logic                 oReject,
   output logic [CW-1:0]        oBit_counter
);

   cipher_state_e state_q, state_d;
   logic          serial_q, serial_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          reject_q, reject_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load, shift, msb;

   piso_shift_reg #(.W(DATA_SIZE)) u_piso (
      .clk_i   (iClk),
      .rst_ni  (iRst),
      .load_i  (load),
      .shift_i (shift),
      .data_i  (iData ^ iKey),
      .msb_o   (msb)
   );

   always_comb begin
      state_d  = state_q;
      serial_d = serial_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      reject_d = 1'b0;
      cnt_d    = cnt_q;
      load     = 1'b0;
      shift    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               if (iData_count == CW'(DATA_SIZE) && iKey_count == CW'(DATA_SIZE)) begin
                  load    = 1'b1;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = LOAD;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         LOAD: state_d = SHIFT;
         SHIFT: begin
            // Enable low freezes the frame: register, counter and bit all hold.
            if (iEn) begin
               serial_d = msb;
               valid_d  = 1'b1;
               shift    = 1'b1;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_SIZE - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q  <= IDLE;
         serial_q <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         reject_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         serial_q <= serial_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         reject_q <= reject_d;
         cnt_q    <= cnt_d;
      end
   end

   assign oSerial      = serial_q;
   assign oValid       = valid_q;
   assign oBusy        = busy_q;
   assign oDone        = done_q;
   assign oReject      = reject_q;
   assign oBit_counter = cnt_q;

endmodule

// File: tb/tb_cipher_serializer.sv
// Bench for cipher_serializer: driver tasks push expected ciphertext bits
// into a queue, a monitor pops and compares on every oValid.
module tb_cipher_serializer;

   localparam int DS = 32;
   localparam int CW = $clog2(DS) + 1;

   logic          iClk = 1'b0;
   logic          iRst = 1'b0;
   logic          iEn = 1'b0;
   logic          iStart = 1'b0;
   logic [DS-1:0] iData = '0;
   logic [DS-1:0] iKey = '0;
   logic [CW-1:0] iData_count = '0;
   logic [CW-1:0] iKey_count = '0;
   logic          oSerial, oValid, oBusy, oDone, oReject;
   logic [CW-1:0] oBit_counter;

   cipher_serializer #(.DATA_SIZE(DS)) dut (
      .iClk         (iClk),
      .iRst         (iRst),
      .iEn          (iEn),
      .iStart       (iStart),
      .iData        (iData),
      .iKey         (iKey),
      .iData_count  (iData_count),
      .iKey_count   (iKey_count),
      .oSerial      (oSerial),
      .oValid       (oValid),
      .oBusy        (oBusy),
      .oDone        (oDone),
      .oReject      (oReject),
      .oBit_counter (oBit_counter)
   );

   // clock / reset block
   always #5 iClk = ~iClk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [0:0] exp_q[$];
   int pass_cnt = 0;
   int chk_cnt = 0;
   int done_seen = 0;
   int done_exp = 0;
   int rej_seen = 0;
   int rej_exp = 0;
   int bits_in_frame = 0;
   int en_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // enable pattern: 0 = always on, 1 = toggling, 2 = random
   always @(negedge iClk) begin
      case (en_mode)
         0: iEn = 1'b1;
         1: iEn = ~iEn;
         default: iEn = 1'($urandom_range(0, 1));
      endcase
   end

   // monitor
   always @(posedge iClk) begin
      logic [0:0] b;
      #1;
      if (!iRst) begin
         bits_in_frame = 0;
      end else begin
         if (oValid) begin
            check("valid_needs_en", iEn, 1);
            if (exp_q.size() == 0) begin
               check("unexpected_bit", oValid, 0);
            end else begin
               b = exp_q.pop_front();
               check("serial_bit", oSerial, b);
               bits_in_frame++;
               check("bit_counter", oBit_counter, bits_in_frame);
            end
         end
         if (oDone) begin
            done_seen++;
            check("done_bits", bits_in_frame, DS);
            check("done_counter", oBit_counter, DS);
            check("done_busy", oBusy, 0);
            bits_in_frame = 0;
         end
         if (oReject) rej_seen++;
      end
   end

   // reference model: ciphertext is data XOR key, sent MSB first
   task automatic push_frame(input logic [DS-1:0] d, input logic [DS-1:0] k);
      logic [DS-1:0] c;
      c = d ^ k;
      for (int i = DS - 1; i >= 0; i--) exp_q.push_back(c[i]);
      done_exp++;
   endtask

   task automatic start_frame(input logic [DS-1:0] d, input logic [DS-1:0] k);
      @(negedge iClk);
      iData = d;
      iKey = k;
      iData_count = CW'(DS);
      iKey_count = CW'(DS);
      iStart = 1'b1;
      push_frame(d, k);
      @(negedge iClk);
      iStart = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_seen < target && n < budget) begin
         @(negedge iClk);
         n++;
      end
      check("done_timeout", done_seen >= target, 1);
   endtask

   task automatic try_reject(input logic [CW-1:0] dc, input logic [CW-1:0] kc);
      @(negedge iClk);
      iData_count = dc;
      iKey_count = kc;
      iData = DS'($urandom);
      iStart = 1'b1;
      rej_exp++;
      @(negedge iClk);
      iStart = 1'b0;
      @(negedge iClk);
      check("reject_count", rej_seen, rej_exp);
      check("reject_busy", oBusy, 0);
   endtask

   initial begin
      int n;
      logic [CW-1:0] bad;
      // reset values
      repeat (2) @(negedge iClk);
      check("rst_serial", oSerial, 0);
      check("rst_valid", oValid, 0);
      check("rst_busy", oBusy, 0);
      check("rst_done", oDone, 0);
      check("rst_reject", oReject, 0);
      check("rst_counter", oBit_counter, 0);
      iRst = 1'b1;
      repeat (2) @(negedge iClk);

      // 1: plain frame, latency of the first bit
      en_mode = 0;
      start_frame(32'h12345678, 32'hFFFFFFFF);
      @(posedge iClk); #2;
      check("lat_load_valid", oValid, 0);
      check("lat_load_busy", oBusy, 1);
      @(posedge iClk); #2;
      check("lat_first_valid", oValid, 1);
      wait_done(done_exp, 200);
      @(negedge iClk);
      check("t1_counter_hold", oBit_counter, DS);
      check("t1_done_pulse", oDone, 0);

      // 2: same frame with toggling enable
      en_mode = 1;
      start_frame(32'h12345678, 32'hFFFFFFFF);
      wait_done(done_exp, 300);

      // 3: incomplete words are refused
      en_mode = 0;
      try_reject(CW'(DS - 1), CW'(DS));
      try_reject(CW'(DS), CW'(3));
      check("reject_no_bits", exp_q.size(), 0);

      // 4: restart and data change during the frame
      en_mode = 2;
      start_frame(32'hCAFEF00D, 32'h13572468);
      repeat (6) @(negedge iClk);
      iData = '0;
      iStart = 1'b1;
      repeat (3) @(negedge iClk);
      iStart = 1'b0;
      wait_done(done_exp, 400);
      check("t4_no_reject", rej_seen, rej_exp);

      // 5: asynchronous reset after 10 bits
      en_mode = 0;
      start_frame(DS'($urandom), DS'($urandom));
      n = 0;
      while (bits_in_frame < 10 && n < 100) begin
         @(negedge iClk);
         n++;
      end
      check("t5_reach_10_bits", bits_in_frame, 10);
      iRst = 1'b0;
      #1;
      check("t5_rst_valid", oValid, 0);
      check("t5_rst_busy", oBusy, 0);
      check("t5_rst_serial", oSerial, 0);
      check("t5_rst_counter", oBit_counter, 0);
      check("t5_rst_done", oDone, 0);
      exp_q.delete();
      done_exp--;
      repeat (2) @(negedge iClk);
      iRst = 1'b1;
      repeat (3) @(negedge iClk);
      check("t5_no_done", done_seen, done_exp);
      start_frame(DS'($urandom), DS'($urandom));
      wait_done(done_exp, 200);

      // 6: iStart held high gives back-to-back frames
      @(negedge iClk);
      iData = 32'hA5A5A5A5;
      iKey = 32'h0F0F0F0F;
      iData_count = CW'(DS);
      iKey_count = CW'(DS);
      iStart = 1'b1;
      push_frame(32'hA5A5A5A5, 32'h0F0F0F0F);
      push_frame(32'hA5A5A5A5, 32'h0F0F0F0F);
      wait_done(done_exp - 1, 200);
      @(negedge iClk);
      check("b2b_reload_busy", oBusy, 1);
      check("b2b_done_single", oDone, 0);
      iStart = 1'b0;
      wait_done(done_exp, 200);

      // random frames with random enable patterns and refused starts
      for (int f = 0; f < 8; f++) begin
         en_mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) begin
            bad = CW'($urandom_range(0, DS - 1));
            try_reject(bad, CW'(DS));
         end
         start_frame(DS'($urandom), DS'($urandom));
         wait_done(done_exp, 400);
      end

      repeat (4) @(negedge iClk);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_done_count", done_seen, done_exp);
      check("final_reject_count", rej_seen, rej_exp);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/cipher_serializer.md
Name: cipher_serializer

Overview:
Downstream stage of the serial-in deserializers in the XOR cipher datapath. Takes the parallel plaintext word and the parallel key word, each produced by a deserializer instance with its bit count. XORs the two words and shifts the ciphertext out one bit per enabled clock, MSB first, with a valid strobe and a done pulse. Also rejects start requests while either input word is incomplete.

Parameters:
- DATA_SIZE, 32: width of the data/key words in bits; must be >= 2.
- CW (localparam), $clog2(DATA_SIZE)+1: counter width, matching the deserializer bit counter.

Ports:
- iClk  input  1  clock
- iRst  input  1  asynchronous active-low reset
- iEn  input  1  shift enable; no shifting while low
- iStart  input  1  request to encrypt and transmit; sampled only in IDLE
- iData  input  DATA_SIZE  parallel plaintext from the data deserializer
- iKey  input  DATA_SIZE  parallel key from the key deserializer
- iData_count  input  CW  data deserializer bit counter
- iKey_count  input  CW  key deserializer bit counter
- oSerial  output  1  ciphertext bit, MSB first
- oValid  output  1  high in each cycle oSerial carries a new bit
- oBusy  output  1  high while in LOAD or SHIFT
- oDone  output  1  one-cycle pulse after the last bit
- oReject  output  1  one-cycle pulse when iStart is refused
- oBit_counter  output  CW  number of bits emitted in the current or last frame

Behaviour:
- Reset (iRst low, asynchronous):
  - state = IDLE; shift register = 0.
  - oSerial, oValid, oBusy, oDone, oReject = 0; oBit_counter = 0.
  - Reset mid-frame aborts the frame immediately; no oDone is produced.
- All outputs are registered.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - oDone, oReject and oValid default to 0 each cycle.
  - iStart with iData_count == DATA_SIZE and iKey_count == DATA_SIZE:
    - shift register <= iData ^ iKey; oBit_counter <= 0; oBusy <= 1; go to LOAD.
  - iStart with either count != DATA_SIZE: oReject <= 1 for one cycle; stay in IDLE.
  - iEn has no effect in IDLE.
- LOAD: one-cycle bubble, taken regardless of iEn; go to SHIFT. oValid = 0.
- SHIFT:
  - iEn = 1:
    - oSerial <= shreg[DATA_SIZE-1]; oValid <= 1.
    - shreg <= {shreg[DATA_SIZE-2:0], 1'b0}; oBit_counter <= oBit_counter + 1.
    - If oBit_counter == DATA_SIZE-1 (this is the last bit), go to DONE.
  - iEn = 0: oValid <= 0; shreg, counter and oSerial hold; remain in SHIFT.
  - iStart is ignored, with no oReject.
- DONE:
  - oValid <= 0; oDone <= 1; oBusy <= 0; go to IDLE.
  - oBit_counter holds DATA_SIZE until the next accepted start.
  - oSerial holds the last bit.
- Latency: accepted iStart at edge N. The first bit is visible after edge N+2, given iEn high. With iEn continuously high, the last bit is visible after edge N+DATA_SIZE+1 and oDone after edge N+DATA_SIZE+2.
- iStart held high across DONE->IDLE is re-evaluated in IDLE, so back-to-back frames are allowed. The minimum gap between frames is one cycle (IDLE).
- iData and iKey are sampled only at acceptance; later changes do not affect the frame in flight.
- Counter width CW always holds DATA_SIZE without wrap.

Decomposition:
- Shared package cipher_pkg:
  - state encoding enum (IDLE=0, LOAD=1, SHIFT=2, DONE=3).
  - DATA_SIZE default and CW helper function.
- The XOR is a single expression; no sub-module for it.
- One natural sub-module: piso_shift_reg (parallel load, enable-gated left shift, MSB out). It is reusable by other transmit paths.

Test Plan:
- Reset, then data=0x12345678, key=0xFFFFFFFF, both counts=32, iStart pulse, iEn=1 -> 32 oValid cycles, bits MSB first = 0xEDCBA987, oDone one pulse, oBit_counter=32.
- Same frame with iEn toggling 1,0,1,0 -> oValid only in iEn=1 cycles, sequence still 0xEDCBA987, no duplicated or dropped bits.
- iStart with iData_count=31, iKey_count=32 -> oReject one-cycle pulse, oBusy stays 0, no oValid.
- iStart re-pulsed mid-SHIFT, and iData changed to 0 after acceptance -> frame unaffected, no oReject, output unchanged.
- iRst asserted after 10 bits of a frame -> all outputs 0 within the same cycle (asynchronous), no oDone; a new start afterwards runs a full 32-bit frame.
- iStart held high with data=0xA5A5A5A5, key=0x0F0F0F0F -> two consecutive frames of 0xAAAAAAAA, one idle cycle between oDone and the next LOAD.
